// File: rtl/low_priority_grant_sequencer_4_2_if.sv
// Request/grant bundle for the 4-requester grant sequencer.
// The consumer side (master) drives requests and Done; the sequencer (slave) returns the grant.
interface low_priority_grant_sequencer_4_2_if;
    logic       Request_0_In;
    logic       Request_1_In;
    logic       Request_2_In;
    logic       Request_3_In;
    logic       Done_In;
    logic       Grant_Valid_Out;
    logic [1:0] Grant_Index_Out;
    logic [3:0] Grant_Onehot_Out;
    logic [3:0] Pending_Out;
    logic       Timeout_Out;

    modport master (
        output Request_0_In, Request_1_In, Request_2_In, Request_3_In, Done_In,
        input  Grant_Valid_Out, Grant_Index_Out, Grant_Onehot_Out, Pending_Out, Timeout_Out
    );

    modport slave (
        input  Request_0_In, Request_1_In, Request_2_In, Request_3_In, Done_In,
        output Grant_Valid_Out, Grant_Index_Out, Grant_Onehot_Out, Pending_Out, Timeout_Out
    );
endinterface

// File: rtl/low_priority_grant_sequencer_4_2.sv
// Sticky-pending 4-requester grant stage: lowest index wins, grant held until Done or timeout.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no grant; picks lowest pending index if any is pending
// ST_GRANT   | grant to idx active; hold counter running
// ST_RELEASE | single dead cycle after a grant; counter cleared
module low_priority_grant_sequencer_4_2 #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                              Clock_In,
    input  logic                              Reset_In,
    low_priority_grant_sequencer_4_2_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [3:0]             pending_q, pending_d;
    logic [1:0]             idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   timeout_q, timeout_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [1:0]             grant_index_q, grant_index_d;
    logic [3:0]             grant_onehot_q, grant_onehot_d;
    logic [3:0]             req;
    logic [3:0]             clear;

    function automatic logic [1:0] lowest_set(input logic [3:0] p);
        if (p[0])      return 2'd0;
        else if (p[1]) return 2'd1;
        else if (p[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        req       = {bus.Request_3_In, bus.Request_2_In, bus.Request_1_In, bus.Request_0_In};
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        clear     = 4'b0000;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (pending_q != 4'b0000) begin
                    state_d = ST_GRANT;
                    idx_d   = lowest_set(pending_q);
                end
            end
            ST_GRANT: begin
                count_d = count_q + COUNT_WIDTH'(1);
                if (bus.Done_In) begin
                    clear   = 4'b0001 << idx_q;
                    state_d = ST_RELEASE;
                end else if (count_q == COUNT_LAST) begin
                    clear     = 4'b0001 << idx_q;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A request on the clearing edge re-arms the bit so it is served again.
        pending_d = (pending_q & ~clear) | req;

        // Grant outputs are registered from the next state so they are glitch-free.
        grant_valid_d  = (state_d == ST_GRANT);
        grant_index_d  = grant_valid_d ? idx_d : 2'b00;
        grant_onehot_d = grant_valid_d ? (4'b0001 << idx_d) : 4'b0000;
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q        <= ST_IDLE;
            pending_q      <= 4'b0000;
            idx_q          <= 2'b00;
            count_q        <= '0;
            timeout_q      <= 1'b0;
            grant_valid_q  <= 1'b0;
            grant_index_q  <= 2'b00;
            grant_onehot_q <= 4'b0000;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            idx_q          <= idx_d;
            count_q        <= count_d;
            timeout_q      <= timeout_d;
            grant_valid_q  <= grant_valid_d;
            grant_index_q  <= grant_index_d;
            grant_onehot_q <= grant_onehot_d;
        end
    end

    assign bus.Grant_Valid_Out  = grant_valid_q;
    assign bus.Grant_Index_Out  = grant_index_q;
    assign bus.Grant_Onehot_Out = grant_onehot_q;
    assign bus.Pending_Out      = pending_q;
    assign bus.Timeout_Out      = timeout_q;

endmodule

// File: doc/low_priority_grant_sequencer_4_2.md
Name: low_priority_grant_sequencer_4_2

Overview:
- Sequential 4-requester grant stage.
- Captures single-cycle or level request strobes into sticky pending bits.
- Grants one requester at a time, choosing the lowest-numbered pending request (index 0 wins), and holds the grant until the consumer signals Done or a timeout expires.
- Sits beside the combinational 4-2 encoders and converts their one-shot priority decision into a registered, handshaken grant.

Parameters:
- TIMEOUT_CYCLES, 16, maximum number of cycles a grant is held without Done_In; legal range 2..(2^COUNT_WIDTH - 1).
- COUNT_WIDTH, 8, width of the internal hold counter.

Ports:
- Clock_In  input  1  single clock; all state updates on the rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Request_0_In  input  1  request from requester 0 (highest priority).
- Request_1_In  input  1  request from requester 1.
- Request_2_In  input  1  request from requester 2.
- Request_3_In  input  1  request from requester 3 (lowest priority).
- Done_In  input  1  consumer releases the current grant; sampled only in GRANT.
- Grant_Valid_Out  output  1  a grant is active.
- Grant_Index_Out  output  2  binary index of the granted requester; 2'b00 when not valid.
- Grant_Onehot_Out  output  4  one-hot form of the grant; 4'b0000 when not valid.
- Pending_Out  output  4  sticky pending request bits, bit i = requester i.
- Timeout_Out  output  1  one-cycle pulse when a grant is dropped by timeout.

Behaviour:
- Reset (asynchronous, any time, including mid-grant):
  - State goes to IDLE.
  - Pending, counter and every output go to 0 immediately.
  - Timeout_Out is not asserted.
- Pending bits:
  - Request_i_In high at a rising edge sets pending[i] at that edge.
  - pending[i] is cleared at the edge its grant completes, by Done or by timeout.
  - If Request_i_In is high on the same edge that clears pending[i], the set wins and pending[i] stays 1, so the request is re-served later.
  - Requests for other indices are captured at every edge regardless of state.
- IDLE:
  - If pending != 0, go to GRANT at the next edge, latching idx = lowest set pending bit.
  - Counter is loaded to 0.
  - Otherwise remain in IDLE.
- GRANT:
  - Grant_Valid_Out = 1, Grant_Index_Out = idx, Grant_Onehot_Out = 1 << idx. All outputs are registered and stable for the whole grant.
  - Counter increments by 1 each cycle.
  - Done_In = 1: clear pending[idx] and go to RELEASE.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: clear pending[idx], pulse Timeout_Out for exactly one cycle (high during the first RELEASE cycle), and go to RELEASE.
  - Done_In and timeout in the same cycle: Done wins and no Timeout_Out pulse is generated.
  - A higher-priority request arriving mid-grant does not preempt the current grant; it is only set in pending.
- RELEASE:
  - Exactly one cycle.
  - Grant_Valid_Out = 0 and grant outputs are 0.
  - Counter is cleared.
  - Unconditionally go to IDLE.
- Done_In outside GRANT is ignored.
- Latency:
  - Request high at edge k sets pending at edge k.
  - FSM enters GRANT at edge k+1, so Grant_Valid_Out is high in the cycle after edge k+1.
  - Minimum back-to-back grant spacing is GRANT(≥1) + RELEASE(1) + IDLE(1) cycles.
- Counter saturation: the counter never wraps, because the timeout forces an exit before it reaches 2^COUNT_WIDTH - 1.
- Timeout_Out: a registered one-cycle pulse; it is never high at the same time as Grant_Valid_Out.

Test Plan:
1. Reset values: Reset_In=1 asserted mid-GRANT (idx=2, counter=5) → all outputs 0 immediately, without waiting for a clock edge. After release, with no requests, the block stays in IDLE and Pending_Out=4'b0000.
2. Single request: Request_2_In pulsed 1 cycle at edge k.
   - Pending_Out=4'b0100 after edge k.
   - Grant_Valid_Out=1, Grant_Index_Out=2'b10, Grant_Onehot_Out=4'b0100 after edge k+1.
   - Done_In=1 for 1 cycle → Grant_Valid_Out=0 and Pending_Out=4'b0000 next cycle.
3. Priority order: Requests 3,1,0 pulsed together → grants issued in order 0, 1, 3, each followed by a 1-cycle RELEASE gap and a 1-cycle IDLE. Pending_Out goes 1011 → 1010 → 1000 → 0000.
4. No preemption: grant active on idx=3 when Request_0_In pulses → Grant_Index_Out stays 2'b11 until Done. Next grant is idx 0.
5. Timeout: TIMEOUT_CYCLES=16, grant idx=1, Done_In held 0.
   - Grant_Valid_Out stays high for exactly 16 cycles.
   - Timeout_Out is high for 1 cycle in the following cycle.
   - pending[1] is cleared.
   - A repeat with Done_In=1 on cycle 16 gives no Timeout_Out pulse.
6. Re-request on clear: Request_0_In high on the same edge that Done_In clears the grant for idx 0 → Pending_Out[0] stays 1, and idx 0 is re-granted after RELEASE+IDLE.
